// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, program-counter defaults and a
// compile-time log2 helper used to build the alignment mask.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int unsigned PC_ADDR_W    = 32;
  localparam logic [31:0] PC_RESET_VEC = '0;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned w = 1; w < value; w = w << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-stage bus between pc_gen and its surroundings: halt/stall/redirect
// inputs from decode/execute, the imem handshake and the fetch address.
// Optional: PC_ALIGN_CHK_EN adds the misalign_o flag.
interface pc_gen_if #(
  parameter int unsigned ADDR_W = cpu_pkg::PC_ADDR_W
);
  logic              halt_i;
  logic              stall_i;
  logic              br_valid_i;
  logic [ADDR_W-1:0] br_target_i;
  logic              imem_ready_i;
  logic              ce_o;
  logic [ADDR_W-1:0] pc_o;
  logic              pc_valid_o;
`ifdef PC_ALIGN_CHK_EN
  logic              misalign_o;

  modport master (
    input  halt_i, stall_i, br_valid_i, br_target_i, imem_ready_i,
    output ce_o, pc_o, pc_valid_o, misalign_o
  );

  modport slave (
    output halt_i, stall_i, br_valid_i, br_target_i, imem_ready_i,
    input  ce_o, pc_o, pc_valid_o, misalign_o
  );
`else
  modport master (
    input  halt_i, stall_i, br_valid_i, br_target_i, imem_ready_i,
    output ce_o, pc_o, pc_valid_o
  );

  modport slave (
    output halt_i, stall_i, br_valid_i, br_target_i, imem_ready_i,
    input  ce_o, pc_o, pc_valid_o
  );
`endif
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for instruction fetch. Advances by STEP on an
// accepted fetch, redirects on br_valid_i (any state), freezes on stall,
// imem back-pressure or halt.
// Optional: PC_ALIGN_CHK_EN clears the low log2(STEP) bits of redirect targets
// and pulses misalign_o the cycle after a misaligned redirect.
import cpu_pkg::*;

module pc_gen #(
  parameter int unsigned       ADDR_W    = PC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
  parameter int unsigned       STEP      = 4
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.master  bus
);

  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

  pc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              acc;
  logic [ADDR_W-1:0] target;

`ifdef PC_ALIGN_CHK_EN
  localparam int unsigned       LSB_W    = clog2(STEP);
  localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((64'd1 << LSB_W) - 64'd1);

  logic misalign_q, misalign_d;
`endif

  // State, PC and flag registers; reset wins over everything on its edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
`ifdef PC_ALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
`ifdef PC_ALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next state and next PC: redirect beats accept beats hold, in every state.
  always_comb begin
    state_d = state_q;
    acc     = (state_q == RUN) & bus.imem_ready_i & ~bus.stall_i;
`ifdef PC_ALIGN_CHK_EN
    target     = bus.br_target_i & ~LSB_MASK;
    misalign_d = bus.br_valid_i & (|(bus.br_target_i & LSB_MASK));
`else
    target     = bus.br_target_i;
`endif

    unique case (state_q)
      BOOT:    state_d = bus.halt_i ? HALT : RUN;
      RUN:     state_d = bus.halt_i ? HALT : RUN;
      HALT:    state_d = bus.halt_i ? HALT : RUN;
      default: state_d = BOOT;
    endcase

    if (bus.br_valid_i) begin
      pc_d = target;
    end else if (acc) begin
      pc_d = pc_q + STEP_A;
    end else begin
      pc_d = pc_q;
    end
  end

  // Fetch outputs are a pure function of the registered state.
  always_comb begin
    bus.ce_o       = (state_q == RUN);
    bus.pc_valid_o = (state_q == RUN);
    bus.pc_o       = pc_q;
`ifdef PC_ALIGN_CHK_EN
    bus.misalign_o = misalign_q;
`endif
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: a 32-bit and an 8-bit instance share one input stream and
// are compared every cycle against a behavioural model; directed steps cover
// reset, streaming, stall, back-pressure, redirect, wrap and halt.
`timescale 1ns/1ps

module tb_pc_gen;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt, stall, br, rdy;
  logic [31:0] tgt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: fetch is active exactly when the previous edge saw no halt/reset.
  bit          m_fetch;
  logic [31:0] m_pc32;
  logic [7:0]  m_pc8;
  bit          m_mis;

  pc_gen_if #(.ADDR_W(32)) if32 ();
  pc_gen_if #(.ADDR_W(8))  if8  ();

  assign if32.halt_i       = halt;
  assign if32.stall_i      = stall;
  assign if32.br_valid_i   = br;
  assign if32.br_target_i  = tgt;
  assign if32.imem_ready_i = rdy;
  assign if8.halt_i        = halt;
  assign if8.stall_i       = stall;
  assign if8.br_valid_i    = br;
  assign if8.br_target_i   = tgt[7:0];
  assign if8.imem_ready_i  = rdy;

  pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .STEP(4)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32)
  );

  pc_gen #(.ADDR_W(8), .RESET_VEC(8'h0), .STEP(4)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit          acc;
    logic [31:0] t;
    if (rst) begin
      m_fetch = 0;
      m_pc32  = 32'h0;
      m_pc8   = 8'h0;
      m_mis   = 0;
    end else begin
      acc = m_fetch && rdy && !stall;
      t   = tgt;
`ifdef PC_ALIGN_CHK_EN
      m_mis = br && (tgt % 4 != 0);
      t     = (tgt / 4) * 4;
`endif
      if (br) begin
        m_pc32 = t;
        m_pc8  = t[7:0];
      end else if (acc) begin
        m_pc32 = m_pc32 + 32'd4;
        m_pc8  = m_pc8 + 8'd4;
      end
      m_fetch = !halt;
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare at negedge.
  task automatic step(input bit r, input bit h, input bit s, input bit b,
                      input logic [31:0] t, input bit rd);
    rst = r; halt = h; stall = s; br = b; tgt = t; rdy = rd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ce32",    {31'd0, if32.ce_o},       {31'd0, m_fetch});
    check("valid32", {31'd0, if32.pc_valid_o}, {31'd0, m_fetch});
    check("pc32",    if32.pc_o,                m_pc32);
    check("ce8",     {31'd0, if8.ce_o},        {31'd0, m_fetch});
    check("valid8",  {31'd0, if8.pc_valid_o},  {31'd0, m_fetch});
    check("pc8",     {24'd0, if8.pc_o},        {24'd0, m_pc8});
`ifdef PC_ALIGN_CHK_EN
    check("mis32",   {31'd0, if32.misalign_o}, {31'd0, m_mis});
    check("mis8",    {31'd0, if8.misalign_o},  {31'd0, m_mis});
`endif
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0; rdy = 1'b0;
    m_fetch = 0; m_pc32 = '0; m_pc8 = '0; m_mis = 0;
    @(negedge clk);

    // Reset held three cycles: BOOT outputs.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h0, 0);
    check("rst_ce",    {31'd0, if32.ce_o},       32'd0);
    check("rst_valid", {31'd0, if32.pc_valid_o}, 32'd0);
    check("rst_pc",    if32.pc_o,                32'h0);

    // First fetch on the second cycle after release, at the reset vector.
    step(0, 0, 0, 0, 32'h0, 1);
    check("boot_valid", {31'd0, if32.pc_valid_o}, 32'd1);
    check("boot_pc",    if32.pc_o,                32'h0);

    // Stream.
    step(0, 0, 0, 0, 32'h0, 1);
    check("stream4", if32.pc_o, 32'h4);
    step(0, 0, 0, 0, 32'h0, 1);
    check("stream8", if32.pc_o, 32'h8);

    // Stall and back-pressure hold the PC.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h0, 1);
    check("stall_hold", if32.pc_o, 32'h8);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 32'h0, 0);
    check("notready_hold", if32.pc_o, 32'h8);

    // Redirect ignores stall, then advance.
    step(0, 0, 1, 1, 32'h100, 0);
    check("redir", if32.pc_o, 32'h100);
    step(0, 0, 0, 0, 32'h0, 1);
    check("redir_adv", if32.pc_o, 32'h104);

    // Halt at 0x20, then resume there.
    step(0, 0, 0, 1, 32'h20, 0);
    step(0, 1, 1, 0, 32'h0, 1);
    check("halt_ce", {31'd0, if32.ce_o}, 32'd0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 32'h0, 1);
    check("halt_pc", if32.pc_o, 32'h20);
    step(0, 0, 0, 0, 32'h0, 1);
    check("resume_ce", {31'd0, if32.ce_o}, 32'd1);
    check("resume_pc", if32.pc_o, 32'h20);
    step(0, 0, 0, 0, 32'h0, 1);
    check("resume_adv", if32.pc_o, 32'h24);

    // Wrap at the top of the address space, both widths.
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    check("wrap_pre8", {24'd0, if8.pc_o}, 32'hFC);
    step(0, 0, 0, 0, 32'h0, 1);
    check("wrap32", if32.pc_o, 32'h0);
    check("wrap8",  {24'd0, if8.pc_o}, 32'h0);

    // Halt together with redirect, and redirect while halted.
    step(0, 1, 0, 1, 32'h40, 1);
    check("halt_br_pc", if32.pc_o, 32'h40);
    step(0, 1, 0, 1, 32'h80, 1);
    check("halted_br_pc", if32.pc_o, 32'h80);
    step(0, 0, 0, 0, 32'h0, 1);
    check("halted_br_resume", if32.pc_o, 32'h80);

`ifdef PC_ALIGN_CHK_EN
    step(0, 0, 0, 1, 32'h102, 0);
    check("mis_pulse", {31'd0, if32.misalign_o}, 32'd1);
    check("mis_pc",    if32.pc_o,                32'h100);
    step(0, 0, 0, 0, 32'h0, 0);
    check("mis_clear", {31'd0, if32.misalign_o}, 32'd0);
`endif

    // Reset mid-run overrides a concurrent redirect.
    step(1, 0, 0, 1, 32'h55, 1);
    check("midrst_pc", if32.pc_o, 32'h0);
    check("midrst_ce", {31'd0, if32.ce_o}, 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 15),
           ($urandom_range(99) < 25), ($urandom_range(99) < 15),
           $urandom, ($urandom_range(99) < 75));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
